// File: rtl/fp32_min_pool_if.sv
// Valid/ready stream bundle for fp32_min_pool: element input side and result output side.
interface fp32_min_pool_if #(
  parameter int unsigned IDX_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [IDX_W-1:0] out_index;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index
  );
endinterface

// File: rtl/fp32_min_pool.sv
// Streaming FP32 min-reduction with argmin over fixed windows of WINDOW elements.
// Optional macro FP_MIN_NAN_PROPAGATE_EN: any NaN makes the window return canonical qNaN.
module fp32_min_pool #(
  parameter int unsigned WINDOW = 4,
  parameter int unsigned IDX_W  = $clog2(WINDOW)
) (
  input  logic           clk,
  input  logic           rst,
  fp32_min_pool_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(WINDOW - 1);

  typedef enum logic [0:0] {ACCUM, HOLD} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   best_q, best_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]    out_index_q, out_index_d;

  logic                in_xfer;
  logic [DATA_W-1:0]   win_data;
  logic [IDX_W-1:0]    win_idx;

`ifdef FP_MIN_NAN_PROPAGATE_EN
  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;
  logic nan_q, nan_d, win_nan;

  function automatic logic is_nan(input logic [DATA_W-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction
`endif

  // Total-order key: negatives bit-inverted, positives sign-flipped, so -0.0 < +0.0.
  function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  assign in_xfer = bus.in_valid && in_ready_q;

  // Winner of the running window including the current element (strict less, earliest wins).
  always_comb begin
    win_data = best_q;
    win_idx  = best_idx_q;
`ifdef FP_MIN_NAN_PROPAGATE_EN
    win_nan  = nan_q;
    if (count_q == '0) begin
      win_data = bus.in_data;
      win_idx  = '0;
      win_nan  = is_nan(bus.in_data);
    end else if (!nan_q && is_nan(bus.in_data)) begin
      win_data = bus.in_data;
      win_idx  = count_q;
      win_nan  = 1'b1;
    end else if (!nan_q && (order_key(bus.in_data) < order_key(best_q))) begin
      win_data = bus.in_data;
      win_idx  = count_q;
    end
`else
    if (count_q == '0) begin
      win_data = bus.in_data;
      win_idx  = '0;
    end else if (order_key(bus.in_data) < order_key(best_q)) begin
      win_data = bus.in_data;
      win_idx  = count_q;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
`ifdef FP_MIN_NAN_PROPAGATE_EN
    nan_d       = nan_q;
`endif
    unique case (state_q)
      ACCUM: begin
        in_ready_d = 1'b1;
        if (in_xfer) begin
          best_d     = win_data;
          best_idx_d = win_idx;
`ifdef FP_MIN_NAN_PROPAGATE_EN
          nan_d      = win_nan;
`endif
          count_d    = count_q + IDX_W'(1);
          if (count_q == LAST_CNT) begin
            state_d     = HOLD;
            count_d     = '0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_index_d = win_idx;
`ifdef FP_MIN_NAN_PROPAGATE_EN
            out_data_d  = win_nan ? QNAN : win_data;
`else
            out_data_d  = win_data;
`endif
          end
        end
      end
      HOLD: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        if (bus.out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
`ifdef FP_MIN_NAN_PROPAGATE_EN
      nan_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
`ifdef FP_MIN_NAN_PROPAGATE_EN
      nan_q       <= nan_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;

endmodule

// File: tb/tb_fp32_min_pool.sv
// Scoreboard bench for fp32_min_pool: directed vectors plus randomized windows vs. a float-ordering model.
module tb_fp32_min_pool;

  localparam int unsigned WINDOW = 4;
  localparam int unsigned IDX_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp32_min_pool_if #(.IDX_W(IDX_W)) bus ();

  fp32_min_pool #(.WINDOW(WINDOW), .IDX_W(IDX_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int bp_mode  = 0;   // 0: always ready, 1: random, 2: stalled
  int gap_max  = 0;

  logic [31:0]      exp_data_q[$];
  logic [IDX_W-1:0] exp_idx_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference ordering from IEEE sign/magnitude rules: negatives below positives,
  // larger magnitude is smaller among negatives.
  function automatic bit fp_less(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a < b;
    return a > b;
  endfunction

  function automatic bit fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  task automatic model(input logic [31:0] w[WINDOW], output logic [31:0] d, output logic [IDX_W-1:0] idx);
    int best = 0;
`ifdef FP_MIN_NAN_PROPAGATE_EN
    for (int i = 0; i < WINDOW; i++) begin
      if (fp_is_nan(w[i])) begin
        d   = 32'h7FC0_0000;
        idx = IDX_W'(i);
        return;
      end
    end
`endif
    for (int i = 1; i < WINDOW; i++)
      if (fp_less(w[i], w[best])) best = i;
    d   = w[best];
    idx = IDX_W'(best);
  endtask

  // Output-ready driver, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on each output transfer and checks HOLD stability.
  logic             hold_prev = 1'b0;
  logic [31:0]      hold_data;
  logic [IDX_W-1:0] hold_idx;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_data", 64'(bus.out_data), 64'(hold_data));
        chk("hold_index", 64'(bus.out_index), 64'(hold_idx));
        chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        hold_prev = 1'b0;
        if (exp_data_q.size() == 0) begin
          chk("unexpected_out", 64'(bus.out_data), 64'hDEAD);
        end else begin
          chk("out_data", 64'(bus.out_data), 64'(exp_data_q.pop_front()));
          chk("out_index", 64'(bus.out_index), 64'(exp_idx_q.pop_front()));
        end
      end else if (bus.out_valid) begin
        hold_prev = 1'b1;
        hold_data = bus.out_data;
        hold_idx  = bus.out_index;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  task automatic send_elem(input logic [31:0] d);
    bit got = 0;
    bus.in_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      $display("FAIL in_ready_timeout: got 0 expected 1");
      failures++;
      checks++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "stalled input");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_window(input logic [31:0] w[WINDOW]);
    logic [31:0]      d;
    logic [IDX_W-1:0] idx;
    model(w, d, idx);
    for (int i = 0; i < WINDOW; i++) send_elem(w[i]);
    exp_data_q.push_back(d);
    exp_idx_q.push_back(idx);
    chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_index", 64'(bus.out_index), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] specials[8] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                 32'h0000_0001, 32'h8000_0001, 32'h3F80_0000, 32'hBF80_0000};
    case ($urandom_range(0, 4))
      0: return specials[$urandom_range(0, 7)];
      1: return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      2: return {1'($urandom_range(0, 1)), 31'h3F80_0000 + 31'($urandom_range(0, 3))};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] w[WINDOW];
    bit drained = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(posedge clk); #1;
    do_reset();

    w = '{32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, 32'hBF00_0000};
    send_window(w);
    w = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    send_window(w);
    w = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h3F80_0000};
    send_window(w);
    w = '{32'h3F80_0000, 32'h7FC0_0001, 32'hFF80_0000, 32'h7F80_0001};
    send_window(w);
    w = '{32'h7F80_0000, 32'h0000_0001, 32'h8000_0001, 32'hFFC0_0000};
    send_window(w);

    // Back-pressure: stall the consumer for 5 cycles after out_valid.
    bp_mode = 2;
    w = '{32'h4100_0000, 32'hC000_0000, 32'hC000_0000, 32'h3F00_0000};
    send_window(w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bp_mode = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.out_valid) break;
    end
    chk("bp_released", 64'(bus.out_valid), 64'd0);
    chk("bp_next_in_ready", 64'(bus.in_ready), 64'd1);

    // Reset mid-window: partial elements must produce nothing.
    send_elem(32'hC120_0000);
    send_elem(32'hC200_0000);
    do_reset();
    w = '{32'h4100_0000, 32'h40A0_0000, 32'h40E0_0000, 32'h40C0_0000};
    send_window(w);

    // Randomized windows with input gaps and random back-pressure.
    gap_max = 3;
    bp_mode = 1;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < WINDOW; i++) w[i] = rand_fp();
      send_window(w);
    end

    bp_mode = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (exp_data_q.size() == 0) begin
        drained = 1;
        break;
      end
    end
    chk("drain", 64'(drained), 64'd1);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
